// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester above the last grant,
// wrapping at n, and reports the grant both one-hot and as an index.
module rr_arbiter #(
    parameter int n = 16,
    parameter int w = 4
) (
    input  logic [0:n-1] req,
    input  logic [w-1:0] last,
    output logic [0:n-1] gnt,
    output logic [w-1:0] idx,
    output logic         any
);

    int pos;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        pos = 0;
        for (int off = 1; off <= n; off++) begin
            pos = (int'(last) + off) % n;
            if (!any && req[pos]) begin
                gnt[pos] = 1'b1;
                idx      = w'(pos);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/async_fifo_mq_reader.sv
// Drains a multi-queue FIFO round-robin into a 3-entry output buffer,
// tagging each word with its source queue index.
module async_fifo_mq_reader #(
    parameter int nr_of_queues = 16,
    parameter int a_hi_size    = 4,
    parameter int data_width   = 36
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [0:nr_of_queues-1] fifo_empty,
    output logic [0:nr_of_queues-1] read,
    input  logic [data_width-1:0]   q,
    output logic [data_width-1:0]   dout,
    output logic [a_hi_size-1:0]    dout_queue,
    output logic                    dout_valid,
    input  logic                    dout_ready,
    output logic                    busy
);

    localparam int buf_depth = 3;

    function automatic logic [a_hi_size-1:0] oh2bin(
        input logic [0:nr_of_queues-1] v
    );
        logic [a_hi_size-1:0] b;
        b = '0;
        for (int i = 0; i < nr_of_queues; i++)
            if (v[i]) b = b | a_hi_size'(i);
        return b;
    endfunction

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'(buf_depth - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    logic [0:nr_of_queues-1] read_q, read_d;
    logic [a_hi_size-1:0]    last_q, last_d;
    logic                    cap_vld_q, cap_vld_d;
    logic [a_hi_size-1:0]    cap_idx_q, cap_idx_d;
    logic [1:0]              occ_q, occ_d;
    logic [1:0]              wr_ptr_q, wr_ptr_d;
    logic [1:0]              rd_ptr_q, rd_ptr_d;
    logic [data_width-1:0]   mem_q [buf_depth];
    logic [data_width-1:0]   mem_d [buf_depth];
    logic [a_hi_size-1:0]    tag_q [buf_depth];
    logic [a_hi_size-1:0]    tag_d [buf_depth];

    logic [0:nr_of_queues-1] req, gnt;
    logic [a_hi_size-1:0]    gnt_idx;
    logic                    gnt_any;
    logic                    push, pop, room;
    logic [2:0]              need;

    // A queue read last cycle still shows a stale empty flag; skip it.
    assign req = ~fifo_empty & ~read_q;

    rr_arbiter #(
        .n (nr_of_queues),
        .w (a_hi_size)
    ) u_arb (
        .req  (req),
        .last (last_q),
        .gnt  (gnt),
        .idx  (gnt_idx),
        .any  (gnt_any)
    );

    assign dout_valid = (occ_q != 2'd0);
    assign pop        = dout_valid && dout_ready;
    assign push       = cap_vld_q;
    assign dout       = mem_q[rd_ptr_q];
    assign dout_queue = tag_q[rd_ptr_q];
    assign read       = read_q;
    assign busy       = (|read_q) | cap_vld_q | dout_valid;

    // Every word already committed to arrive must have a slot reserved.
    assign need = {1'b0, occ_q} + {2'b0, cap_vld_q} + {2'b0, |read_q};
    assign room = (need - {2'b0, pop}) < 3'(buf_depth);

    always_comb begin
        read_d    = '0;
        last_d    = last_q;
        cap_vld_d = |read_q;
        cap_idx_d = oh2bin(read_q);
        occ_d     = occ_q + 2'(push) - 2'(pop);
        wr_ptr_d  = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d  = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        mem_d     = mem_q;
        tag_d     = tag_q;
        if (enable && gnt_any && room) begin
            read_d = gnt;
            last_d = gnt_idx;
        end
        if (push) begin
            mem_d[wr_ptr_q] = q;
            tag_d[wr_ptr_q] = cap_idx_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            read_q    <= '0;
            last_q    <= a_hi_size'(nr_of_queues - 1);
            cap_vld_q <= 1'b0;
            cap_idx_q <= '0;
            occ_q     <= 2'd0;
            wr_ptr_q  <= 2'd0;
            rd_ptr_q  <= 2'd0;
            for (int i = 0; i < buf_depth; i++) begin
                mem_q[i] <= '0;
                tag_q[i] <= '0;
            end
        end else begin
            read_q    <= read_d;
            last_q    <= last_d;
            cap_vld_q <= cap_vld_d;
            cap_idx_q <= cap_idx_d;
            occ_q     <= occ_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            mem_q     <= mem_d;
            tag_q     <= tag_d;
        end
    end

endmodule

// File: tb/tb_async_fifo_mq_reader.sv
// Scoreboard bench for async_fifo_mq_reader with a behavioural
// multi-queue FIFO model feeding q one cycle after each read strobe.
module tb_async_fifo_mq_reader;

    localparam int NQ = 16;
    localparam int AW = 4;
    localparam int DW = 36;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          dout_ready = 1'b0;
    logic [0:NQ-1] fifo_empty;
    logic [0:NQ-1] read;
    logic [DW-1:0] q = '0;
    logic [DW-1:0] dout;
    logic [AW-1:0] dout_queue;
    logic          dout_valid;
    logic          busy;

    async_fifo_mq_reader #(
        .nr_of_queues (NQ),
        .a_hi_size    (AW),
        .data_width   (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .read       (read),
        .q          (q),
        .dout       (dout),
        .dout_queue (dout_queue),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] qi;
        logic [DW-1:0] d;
    } exp_t;

    int   cnt [NQ];
    int   seq [NQ];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    exp_t sb [$];
    int   rd_idx_log [$];
    int   rd_cyc_log [$];
    int   pop_cyc_log [$];

    always_comb begin
        for (int i = 0; i < NQ; i++) fifo_empty[i] = (cnt[i] == 0);
    end

    always @(posedge clk) cyc++;

    function automatic logic [DW-1:0] word(int qi, int s);
        logic [3:0]  a;
        logic [31:0] b;
        a = 4'(qi);
        b = 32'(s);
        return {a, b};
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(int qi, int s);
        exp_t e;
        e.qi = 4'(qi);
        e.d  = word(qi, s);
        sb.push_back(e);
    endtask

    task automatic setq(int qi, int n);
        cnt[qi] = n;
        seq[qi] = 0;
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        rd_idx_log.delete();
        rd_cyc_log.delete();
        pop_cyc_log.delete();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        enable = 1'b0;
        dout_ready = 1'b0;
        for (int i = 0; i < NQ; i++) setq(i, 0);
        sb.delete();
        tick(2);
        clear_logs();
        rst = 1'b1;
        tick(1);
    endtask

    task automatic wait_drain(string name, int bound);
        int k;
        k = 0;
        while ((sb.size() != 0 || busy) && k < bound) begin
            @(posedge clk);
            #1;
            k++;
        end
        n_cmp++;
        if (k >= bound) begin
            n_bad++;
            $display("FAIL %s_drain: %0d words left, busy %0b", name, sb.size(), busy);
        end
    endtask

    task automatic wait_read(string name);
        int k;
        k = 0;
        while (read == '0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (k >= 20) begin
            n_bad++;
            $display("FAIL %s_no_read: got none expected a read", name);
        end
    endtask

    task automatic chk_seq(string name, input int exp[$]);
        chk({name, "_nreads"}, rd_idx_log.size(), exp.size());
        if (rd_idx_log.size() == exp.size())
            foreach (exp[k]) chk({name, "_rd_idx"}, rd_idx_log[k], exp[k]);
    endtask

    // FIFO model: a strobe seen mid-cycle pops that queue at the edge.
    initial begin : fifo_model
        logic [0:NQ-1] r;
        forever begin
            @(negedge clk);
            r = read;
            @(posedge clk);
            #2;
            for (int i = 0; i < NQ; i++) begin
                if (r[i]) begin
                    if (cnt[i] == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL empty_read: queue %0d read while empty", i);
                    end else begin
                        q = word(i, seq[i]);
                        seq[i]++;
                        cnt[i]--;
                    end
                end
            end
        end
    end

    initial begin : monitor
        exp_t e;
        int   ix;
        forever begin
            @(negedge clk);
            if (read != '0) begin
                n_cmp++;
                if ($countones(read) != 1) begin
                    n_bad++;
                    $display("FAIL read_onehot: got %h expected one-hot", read);
                end
                ix = 0;
                for (int i = 0; i < NQ; i++) if (read[i]) ix = i;
                rd_idx_log.push_back(ix);
                rd_cyc_log.push_back(cyc);
            end
            if (rst && dout_valid && dout_ready) begin
                pop_cyc_log.push_back(cyc);
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL extra_word: got queue %0d expected none", dout_queue);
                end else begin
                    e = sb.pop_front();
                    chk("dout_queue", dout_queue, e.qi);
                    chk("dout", dout, e.d);
                end
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        int e4[$];
        #1 rst = 1'b0;
        for (int i = 0; i < NQ; i++) setq(i, 0);
        @(negedge clk);
        chk("rst_read", read, 0);
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_dout", dout, 0);
        chk("rst_dout_queue", dout_queue, 0);

        // Two queues alternate at one read per clock.
        do_reset();
        setq(2, 2);
        setq(5, 2);
        push_exp(2, 0); push_exp(5, 0); push_exp(2, 1); push_exp(5, 1);
        dout_ready = 1'b1;
        enable = 1'b1;
        wait_drain("t1", 50);
        e4 = '{2, 5, 2, 5};
        chk_seq("t1", e4);
        if (rd_cyc_log.size() == 4) begin
            for (int k = 1; k < 4; k++)
                chk("t1_rd_gap", rd_cyc_log[k] - rd_cyc_log[k-1], 1);
        end
        if (rd_cyc_log.size() > 0 && pop_cyc_log.size() > 0)
            chk("t1_latency", pop_cyc_log[0] - rd_cyc_log[0], 2);

        // Single queue: a read every other cycle.
        do_reset();
        setq(7, 4);
        for (int s = 0; s < 4; s++) push_exp(7, s);
        dout_ready = 1'b1;
        enable = 1'b1;
        wait_drain("t2", 50);
        e4 = '{7, 7, 7, 7};
        chk_seq("t2", e4);
        if (rd_cyc_log.size() == 4) begin
            for (int k = 1; k < 4; k++)
                chk("t2_rd_gap", rd_cyc_log[k] - rd_cyc_log[k-1], 2);
        end

        // Stalled consumer: the buffer fills after exactly three reads.
        do_reset();
        for (int i = 0; i < NQ; i++) begin
            setq(i, 1);
            push_exp(i, 0);
        end
        enable = 1'b1;
        tick(12);
        e4 = '{0, 1, 2};
        chk_seq("t3", e4);
        chk("t3_read_idle", read, 0);
        chk("t3_dout_valid", dout_valid, 1);
        chk("t3_dout_queue", dout_queue, 0);
        chk("t3_dout", dout, word(0, 0));
        chk("t3_busy", busy, 1);
        dout_ready = 1'b1;
        wait_drain("t3", 100);
        chk("t3_total_reads", rd_idx_log.size(), 16);

        // Wrap-around from queue 15 to queue 0.
        do_reset();
        setq(15, 1);
        push_exp(15, 0);
        dout_ready = 1'b1;
        enable = 1'b1;
        wait_drain("t4a", 50);
        cnt[15] = 1;
        setq(0, 1);
        push_exp(0, 0);
        push_exp(15, 1);
        wait_drain("t4b", 50);
        e4 = '{15, 0, 15};
        chk_seq("t4", e4);

        // Enable dropped right after a read.
        do_reset();
        setq(3, 3);
        push_exp(3, 0);
        dout_ready = 1'b1;
        enable = 1'b1;
        wait_read("t5");
        @(posedge clk);
        #1 enable = 1'b0;
        wait_drain("t5", 50);
        tick(4);
        chk("t5_nreads", rd_idx_log.size(), 1);
        chk("t5_busy", busy, 0);
        chk("t5_dout_valid", dout_valid, 0);
        chk("t5_left", cnt[3], 2);

        // Reset while two words are buffered and one is in flight.
        do_reset();
        setq(1, 1);
        setq(2, 1);
        setq(3, 1);
        enable = 1'b1;
        wait_read("t6");
        repeat (3) @(negedge clk);
        chk("t6_pre_valid", dout_valid, 1);
        chk("t6_pre_busy", busy, 1);
        rst = 1'b0;
        #1;
        chk("t6_rst_valid", dout_valid, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_read", read, 0);
        for (int i = 0; i < NQ; i++) setq(i, 0);
        sb.delete();
        tick(2);
        clear_logs();
        setq(6, 1);
        setq(9, 1);
        push_exp(6, 0);
        push_exp(9, 0);
        dout_ready = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        chk("t6_post_read", read, 0);
        wait_drain("t6", 50);
        e4 = '{6, 9};
        chk_seq("t6", e4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/async_fifo_mq_reader.md
ASYNC_FIFO_MQ_READER -- requirements
Module: async_fifo_mq_reader

Interface
REQ-001 SHALL have parameter nr_of_queues, default 16, number of queues drained.
REQ-002 SHALL have parameter a_hi_size, default 4, queue-index width; 2**a_hi_size >= nr_of_queues.
REQ-003 SHALL have parameter data_width, default 36, word width.
REQ-004 SHALL have port clk  input  1  the only clock, the multi-queue FIFO read-side clock.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port enable  input  1  high permits new FIFO reads.
REQ-007 SHALL have port fifo_empty  input  [0:nr_of_queues-1]  per-queue empty flags from the FIFO.
REQ-008 SHALL have port read  output  [0:nr_of_queues-1]  one-hot FIFO read strobe.
REQ-009 SHALL have port q  input  data_width  FIFO read data, valid the cycle after read.
REQ-010 SHALL have port dout  output  data_width  head word of the output buffer.
REQ-011 SHALL have port dout_queue  output  a_hi_size  binary source-queue index of dout.
REQ-012 SHALL have port dout_valid  output  1  dout/dout_queue hold a word.
REQ-013 SHALL have port dout_ready  input  1  consumer accepts the word when high with dout_valid.
REQ-014 SHALL have port busy  output  1  high while a read is in flight or the buffer is non-empty.

Function
REQ-015 read SHALL be all-zero or exactly one-hot, and driven from registers.
REQ-016 Eligible queue in cycle N: fifo_empty[i]==0 and i not read in cycle N-1.
REQ-017 A read SHALL be issued in cycle N iff enable==1, an eligible queue exists, and occ+inflight<3; occ is the output-buffer count (0..3), inflight is 1 if a read was issued in N-1.
REQ-018 Selection SHALL be round-robin: first eligible queue scanning upward from (last granted + 1) mod nr_of_queues, with wrap-around.
REQ-019 The word on q in cycle N+1 SHALL be written into the output buffer, tagged with the index read in cycle N.
REQ-020 Output buffer SHALL be a 3-entry FIFO; pop on dout_valid && dout_ready; simultaneous push and pop leaves occ unchanged.
REQ-021 Word order at dout SHALL equal read-issue order; no word is dropped or duplicated.
REQ-022 dout/dout_queue SHALL stay stable while dout_valid && !dout_ready.
REQ-023 Deasserting enable SHALL stop new reads next cycle; the in-flight word is still captured.
REQ-024 Sustained throughput SHALL be 1 word/clk with >=2 non-empty queues and dout_ready high; 1 word per 2 clk with one queue.
REQ-025 busy SHALL equal (inflight | occ!=0).

Reset
REQ-026 On rst low: read=0, dout_valid=0, busy=0, occ=0, inflight=0, round-robin pointer such that queue 0 is first priority; dout and dout_queue = 0.
REQ-027 Reset mid-operation SHALL discard buffered and in-flight words; no read asserts during or in the first cycle after reset release.

Structure
REQ-028 Round-robin arbiter SHALL be sub-module rr_arbiter (request vector, last-grant pointer -> one-hot grant, binary index).
REQ-029 No shared package; onehot-to-binary conversion is a local function; buffer depth 3 is a local constant.

Verification
REQ-030 Queues 2 and 5 non-empty, dout_ready=1 -> reads 2,5,2,5 on consecutive cycles; dout_queue 2,5,2,5 from cycle 2 after first read.
REQ-031 Only queue 7 non-empty, 4 words -> read[7] every other cycle; 4 words out with dout_queue=7.
REQ-032 All 16 queues non-empty, dout_ready=0 -> exactly 3 reads (queues 0,1,2), then read=0; dout_valid high holding queue-0 word.
REQ-033 Grant at queue 15, queues 15 and 0 non-empty -> next grant queue 0 (wrap).
REQ-034 enable dropped in the cycle after a read -> no further read; that word still appears on dout; busy falls after pop.
REQ-035 rst low with occ=2, inflight=1 -> dout_valid=0, busy=0 immediately; after release the first grant goes to lowest non-empty queue.
